// File: rtl/uart_chunk_defs.sv
// Chunk state encodings and byte-lane convention shared by the RX assembler and TX chunker.
// Byte i of a chunk always occupies bits [i*8+7 : i*8] of the packed chunk bus.
package uart_chunk_defs;

  localparam logic [0:0] ST_COLLECTING = 1'b0;
  localparam logic [0:0] ST_READY      = 1'b1;

  localparam int CHUNK_BYTE_W = 8;

  function automatic int byte_lsb(input int idx);
    return idx * CHUNK_BYTE_W;
  endfunction

endpackage

// File: rtl/chunk_idle_timer.sv
// Idle timer: counts enabled cycles since the last clear, strobes expire on the final count.
// Expire is asserted combinationally in the cycle whose rising edge completes the timeout.
module chunk_idle_timer #(
  parameter int IDLE_TIMEOUT_CYCLES = 1000
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic run,
  output logic expire
);

  if (IDLE_TIMEOUT_CYCLES == 0) begin : g_off
    logic unused_in;
    assign unused_in = CLK ^ RST ^ clear ^ run;
    assign expire    = 1'b0;
  end else begin : g_on
    localparam int CW = $clog2(IDLE_TIMEOUT_CYCLES + 1);
    logic [CW-1:0] idle_cnt;

    // Counter holds cycles already elapsed, so the edge that would make it
    // reach the timeout is the one that flushes.
    assign expire = run && !clear && (idle_cnt == CW'(IDLE_TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK) begin
      if (RST || clear) begin
        idle_cnt <= '0;
      end else if (run) begin
        if (expire) idle_cnt <= '0;
        else        idle_cnt <= idle_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_chunk_assembler.sv
// Gathers UART RX bytes into a chunk, flushing when full or after an idle timeout.
// Registered outputs; bytes arriving while a chunk is pending are dropped with an overflow pulse.
module uart_rx_chunk_assembler
  import uart_chunk_defs::*;
#(
  parameter int BUFFER_BYTE_SIZE    = 3,
  parameter int BUFFER_INDEX_SIZE   = 32,
  parameter int IDLE_TIMEOUT_CYCLES = 1000
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            is_rx_valid,
  input  logic [7:0]                      rx_data,
  input  logic                            is_chunk_consumed,
  output logic                            is_chunk_ready,
  output logic [BUFFER_INDEX_SIZE-1:0]    chunk_byte_size,
  output logic [BUFFER_BYTE_SIZE*8-1:0]   chunk_bytes,
  output logic                            is_overflow
);

  localparam int BUFFER_W = BUFFER_BYTE_SIZE * 8;
  localparam logic [BUFFER_INDEX_SIZE-1:0] FULL_COUNT = BUFFER_INDEX_SIZE'(BUFFER_BYTE_SIZE);
  localparam logic [BUFFER_INDEX_SIZE-1:0] ONE        = BUFFER_INDEX_SIZE'(1);

  logic [0:0]                   state;
  logic [BUFFER_INDEX_SIZE-1:0] byte_idx;
  logic [BUFFER_INDEX_SIZE-1:0] next_idx;
  logic [BUFFER_W-1:0]          buffer;
  logic                         timer_clear;
  logic                         timer_run;
  logic                         timer_expire;

  assign next_idx    = byte_idx + ONE;
  assign timer_clear = is_rx_valid || (state == ST_READY);
  assign timer_run   = (state == ST_COLLECTING) && (byte_idx != '0);

  chunk_idle_timer #(
    .IDLE_TIMEOUT_CYCLES(IDLE_TIMEOUT_CYCLES)
  ) u_idle_timer (
    .CLK    (CLK),
    .RST    (RST),
    .clear  (timer_clear),
    .run    (timer_run),
    .expire (timer_expire)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state           <= ST_COLLECTING;
      byte_idx        <= '0;
      buffer          <= '0;
      chunk_byte_size <= '0;
      is_chunk_ready  <= 1'b0;
      is_overflow     <= 1'b0;
    end else begin
      is_overflow <= 1'b0;
      case (state)
        ST_COLLECTING: begin
          if (is_rx_valid) begin
            for (int i = 0; i < BUFFER_BYTE_SIZE; i++) begin
              if (byte_idx == BUFFER_INDEX_SIZE'(i))
                buffer[byte_lsb(i) +: CHUNK_BYTE_W] <= rx_data;
            end
            byte_idx <= next_idx;
            if (next_idx == FULL_COUNT) begin
              state           <= ST_READY;
              is_chunk_ready  <= 1'b1;
              chunk_byte_size <= FULL_COUNT;
            end
          end else if (timer_expire) begin
            state           <= ST_READY;
            is_chunk_ready  <= 1'b1;
            chunk_byte_size <= byte_idx;
          end
        end
        default: begin
          if (is_chunk_consumed) begin
            if (is_rx_valid) begin
              // The accepted byte opens the next chunk; with a one-byte chunk it is already full.
              buffer   <= BUFFER_W'(rx_data);
              byte_idx <= ONE;
              if (ONE == FULL_COUNT) begin
                state           <= ST_READY;
                is_chunk_ready  <= 1'b1;
                chunk_byte_size <= ONE;
              end else begin
                state           <= ST_COLLECTING;
                is_chunk_ready  <= 1'b0;
                chunk_byte_size <= '0;
              end
            end else begin
              state           <= ST_COLLECTING;
              is_chunk_ready  <= 1'b0;
              chunk_byte_size <= '0;
              buffer          <= '0;
              byte_idx        <= '0;
            end
          end else if (is_rx_valid) begin
            is_overflow <= 1'b1;
          end
        end
      endcase
    end
  end

  assign chunk_bytes = buffer;

endmodule

// File: tb/tb_uart_rx_chunk_assembler.sv
// Directed self-checking bench for uart_rx_chunk_assembler with a 3-byte chunk and 16-cycle timeout.
module tb_uart_rx_chunk_assembler;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        is_rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        is_chunk_consumed = 1'b0;
  logic        is_chunk_ready;
  logic [31:0] chunk_byte_size;
  logic [23:0] chunk_bytes;
  logic        is_overflow;

  int tests_run = 0;
  int tests_failed = 0;

  uart_rx_chunk_assembler #(
    .BUFFER_BYTE_SIZE(3),
    .BUFFER_INDEX_SIZE(32),
    .IDLE_TIMEOUT_CYCLES(16)
  ) dut (
    .CLK               (CLK),
    .RST               (RST),
    .is_rx_valid       (is_rx_valid),
    .rx_data           (rx_data),
    .is_chunk_consumed (is_chunk_consumed),
    .is_chunk_ready    (is_chunk_ready),
    .chunk_byte_size   (chunk_byte_size),
    .chunk_bytes       (chunk_bytes),
    .is_overflow       (is_overflow)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One rising edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    is_rx_valid = 1'b1;
    rx_data     = b;
    tick();
    is_rx_valid = 1'b0;
  endtask

  task automatic consume();
    is_chunk_consumed = 1'b1;
    tick();
    is_chunk_consumed = 1'b0;
  endtask

  initial begin
    idle(2);
    RST = 1'b0;
    check("reset_ready", 64'(is_chunk_ready), 64'd0);
    check("reset_size", 64'(chunk_byte_size), 64'd0);
    check("reset_bytes", 64'(chunk_bytes), 64'd0);
    check("reset_ovf", 64'(is_overflow), 64'd0);

    // Full chunk
    send_byte(8'h41); idle(9);
    send_byte(8'h42); idle(9);
    check("full_not_yet", 64'(is_chunk_ready), 64'd0);
    send_byte(8'h43);
    check("full_ready", 64'(is_chunk_ready), 64'd1);
    check("full_size", 64'(chunk_byte_size), 64'd3);
    check("full_bytes", 64'(chunk_bytes), 64'h434241);

    // Overflow while pending
    send_byte(8'h99);
    check("ovf_pulse", 64'(is_overflow), 64'd1);
    check("ovf_bytes_held", 64'(chunk_bytes), 64'h434241);
    check("ovf_size_held", 64'(chunk_byte_size), 64'd3);
    tick();
    check("ovf_pulse_end", 64'(is_overflow), 64'd0);
    check("ovf_still_ready", 64'(is_chunk_ready), 64'd1);

    consume();
    check("consume_ready", 64'(is_chunk_ready), 64'd0);
    check("consume_size", 64'(chunk_byte_size), 64'd0);
    check("consume_bytes", 64'(chunk_bytes), 64'd0);

    // Empty buffer never times out
    idle(20);
    check("empty_no_flush", 64'(is_chunk_ready), 64'd0);

    // Timeout flush of a single byte
    send_byte(8'h55);
    idle(15);
    check("to_before", 64'(is_chunk_ready), 64'd0);
    idle(1);
    check("to_ready", 64'(is_chunk_ready), 64'd1);
    check("to_size", 64'(chunk_byte_size), 64'd1);
    check("to_bytes", 64'(chunk_bytes), 64'h000055);
    consume();

    // 15-cycle gap does not flush
    send_byte(8'h60); idle(14);
    send_byte(8'h61);
    check("gap15_no_flush", 64'(is_chunk_ready), 64'd0);
    idle(15);
    check("gap15_before", 64'(is_chunk_ready), 64'd0);
    idle(1);
    check("gap15_ready", 64'(is_chunk_ready), 64'd1);
    check("gap15_size", 64'(chunk_byte_size), 64'd2);
    check("gap15_bytes", 64'(chunk_bytes), 64'h006160);
    consume();

    // Simultaneous consume + byte
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    check("sim_pending", 64'(is_chunk_ready), 64'd1);
    is_chunk_consumed = 1'b1;
    is_rx_valid = 1'b1;
    rx_data = 8'h77;
    tick();
    is_chunk_consumed = 1'b0;
    is_rx_valid = 1'b0;
    check("sim_ready", 64'(is_chunk_ready), 64'd0);
    check("sim_no_ovf", 64'(is_overflow), 64'd0);
    idle(15);
    check("sim_before", 64'(is_chunk_ready), 64'd0);
    idle(1);
    check("sim_ready2", 64'(is_chunk_ready), 64'd1);
    check("sim_size", 64'(chunk_byte_size), 64'd1);
    check("sim_bytes", 64'(chunk_bytes), 64'h000077);
    consume();

    // Reset mid-collection
    send_byte(8'hA1); send_byte(8'hA2);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rst_ready", 64'(is_chunk_ready), 64'd0);
    check("rst_size", 64'(chunk_byte_size), 64'd0);
    check("rst_bytes", 64'(chunk_bytes), 64'd0);
    check("rst_ovf", 64'(is_overflow), 64'd0);
    send_byte(8'h01); send_byte(8'h02);
    check("rst_partial", 64'(is_chunk_ready), 64'd0);
    send_byte(8'h03);
    check("rst_ready2", 64'(is_chunk_ready), 64'd1);
    check("rst_size2", 64'(chunk_byte_size), 64'd3);
    check("rst_bytes2", 64'(chunk_bytes), 64'h030201);
    consume();

    // Byte arriving on the expiry edge wins
    send_byte(8'h10); idle(15);
    send_byte(8'hAA);
    check("exp_no_flush", 64'(is_chunk_ready), 64'd0);
    idle(15);
    check("exp_before", 64'(is_chunk_ready), 64'd0);
    idle(1);
    check("exp_ready", 64'(is_chunk_ready), 64'd1);
    check("exp_size", 64'(chunk_byte_size), 64'd2);
    check("exp_bytes", 64'(chunk_bytes), 64'h00AA10);
    consume();
    check("final_ready", 64'(is_chunk_ready), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_rx_chunk_assembler.md
# uart_rx_chunk_assembler

Receive-side counterpart of the chunked UART TX path. Collects single bytes from the UART RX byte module into a `BUFFER_BYTE_SIZE`-byte buffer. Presents a completed chunk (buffer plus fill count) with a level-held ready/consume handshake. A chunk completes when the buffer fills, or when the line has been idle for a set time after at least one byte arrived. The output chunk format matches the TX chunker input, so the two can be looped back.

## Interface
- `BUFFER_BYTE_SIZE`, 3: chunk capacity in bytes; must be ≥1.
- `BUFFER_INDEX_SIZE`, 32: width of byte count/index.
- `IDLE_TIMEOUT_CYCLES`, 1000: idle cycles after last accepted byte before a partial chunk is flushed; 0 disables the timeout.

- `CLK` in 1: single clock, all logic on rising edge.
- `RST` in 1: synchronous, active-high reset.
- `is_rx_valid` in 1: one-cycle pulse from UART RX; `rx_data` is valid in that cycle.
- `rx_data` in 8: received byte.
- `is_chunk_consumed` in 1: consumer acknowledge, sampled only while `is_chunk_ready`=1.
- `is_chunk_ready` out 1: chunk available; held high until consumed.
- `chunk_byte_size` out BUFFER_INDEX_SIZE: number of valid bytes, 1..BUFFER_BYTE_SIZE, while ready.
- `chunk_bytes` out BUFFER_BYTE_SIZE*8: byte i at bits [i*8+7 : i*8]; bytes at index ≥ size read 0.
- `is_overflow` out 1: one-cycle pulse per byte dropped.

## Operation
- Two states:
  - **COLLECTING**: reset state; `is_chunk_ready`=0.
  - **READY**: `is_chunk_ready`=1.
- Reset values: state COLLECTING; `is_chunk_ready`, `chunk_byte_size`, `chunk_bytes`, `is_overflow`, byte index and idle counter all 0.
- COLLECTING, `is_rx_valid`=1:
  - Store `rx_data` at the current index, increment the index, clear the idle counter.
  - If the new count equals BUFFER_BYTE_SIZE, go to READY with size = BUFFER_BYTE_SIZE.
- COLLECTING, no byte, count>0, timeout enabled:
  - Increment the idle counter.
  - When it reaches IDLE_TIMEOUT_CYCLES, go to READY with size = current count.
- COLLECTING with count=0: the idle counter never runs, so no empty chunk is ever emitted.
- Byte arriving in the same cycle the timer would expire: the byte wins. It is accepted, the counter clears, and there is no flush (or the chunk goes READY via the full condition).
- READY:
  - Buffer, size and ready are held stable.
  - Any `is_rx_valid` without `is_chunk_consumed` drops the byte and pulses `is_overflow` for 1 cycle.
- READY, `is_chunk_consumed`=1:
  - Go to COLLECTING.
  - Clear the buffer, size and index.
- Consume and `is_rx_valid` in the same cycle: the byte is stored as byte 0 of the next chunk (count=1, idle counter 0). It is not an overflow.
- `RST` mid-operation: a partially collected or pending chunk is discarded and all outputs return to reset values.
- Index/size arithmetic is at BUFFER_INDEX_SIZE width. The idle counter is sized to hold IDLE_TIMEOUT_CYCLES.

## Timing
- Filling byte sampled at edge E: `is_chunk_ready`=1 and the size is valid from edge E+1.
- Timeout: last byte sampled at edge E, no further bytes: `is_chunk_ready` rises at edge E+IDLE_TIMEOUT_CYCLES.
- Consume sampled at edge C: `is_chunk_ready`=0 from edge C+1. The earliest next ready is edge C+1 with BUFFER_BYTE_SIZE=1.
- `is_overflow` is high for exactly the cycle after the edge at which the byte was dropped.
- No combinational path from inputs to outputs; all outputs are registered.

## Structure
- Shared definitions file `uart_chunk_defs`: state encodings (COLLECTING/READY), and the chunk byte-order convention shared with the TX chunker.
- One natural sub-module, `chunk_idle_timer`:
  - Inputs: clear, run enable.
  - Output: expire strobe.
  - Parameterised by IDLE_TIMEOUT_CYCLES; tied off when it is 0.

## Test plan
All tests use BUFFER_BYTE_SIZE=3, IDLE_TIMEOUT_CYCLES=16.
- **Full chunk**: after reset, bytes 0x41, 0x42, 0x43 spaced 10 cycles → ready 1 cycle after 0x43, size 3, `chunk_bytes`=0x434241; consume → ready 0 next cycle, size 0.
- **Timeout flush**: single byte 0x55, then idle → ready exactly 16 cycles after the byte edge, size 1, `chunk_bytes`=0x000055; a 15-cycle gap before a second byte produces no flush.
- **Overflow**: full chunk pending, send 0x99 → `is_overflow` 1-cycle pulse, chunk still 0x434241 and size 3.
- **Simultaneous consume + byte**: consume with 0x77 in the same cycle → ready 0, no overflow; 16 idle cycles later ready with size 1, `chunk_bytes`=0x000077.
- **Reset mid-collection**: 2 bytes, then `RST` for 1 cycle → all outputs 0; next 0x01, 0x02, 0x03 → `chunk_bytes`=0x030201, size 3.
- **Byte at expiry**: byte 0xAA at cycle 16 after byte 0x10 → no flush, count 2; later flush → size 2, `chunk_bytes`=0x00AA10.
